weight_bank_loader: RTL

- Parametrised weight register bank that accepts LANES weights per beat over a valid/ready stream.
- Fills a shadow bank in descending index order (index N_REG-1 first).
- On a swap request, commits the complete set to an active bank that drives the flattened all_weight output to the conv datapath.
- Next generation of the two-weight register file: adds configurable lanes, load sequencing, handshake and double-buffering.

---
 rtl/weight_pkg.sv | 20 ++
 rtl/weight_bank_loader_if.sv | 33 +++
 rtl/weight_bank_ctrl.sv | 112 +++++++++++
 rtl/weight_bank_loader.sv | 89 ++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared definitions for the weight bank loader slice: controller state
// encoding, default geometry and the load-counter width helper.
package weight_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_N_REG = 31;
   localparam int unsigned DEF_LANES = 2;

   // load_count must represent 0..n_reg inclusive
   function automatic int unsigned cnt_width(input int unsigned n_reg);
      return $clog2(n_reg + 1);
   endfunction

endpackage

// File: rtl/weight_bank_loader_if.sv
// Weight bank loader bus: load stream (start/w_in/w_valid/w_ready), commit
// (swap), status (loaded/bank_valid/load_count) and the flattened active bank.
//   master : weight source / controller side
//   slave  : weight_bank_loader
interface weight_bank_loader_if
   import weight_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned N_REG = DEF_N_REG,
   parameter int unsigned LANES = DEF_LANES
);
   localparam int unsigned CNT_W = cnt_width(N_REG);

   logic                   start;
   logic [WIDTH*LANES-1:0] w_in;
   logic                   w_valid;
   logic                   w_ready;
   logic                   swap;
   logic                   loaded;
   logic                   bank_valid;
   logic [CNT_W-1:0]       load_count;
   logic [WIDTH*N_REG-1:0] all_weight;

   modport master (
      output start, w_in, w_valid, swap,
      input  w_ready, loaded, bank_valid, load_count, all_weight
   );

   modport slave (
      input  start, w_in, w_valid, swap,
      output w_ready, loaded, bank_valid, load_count, all_weight
   );
endinterface

// File: rtl/weight_bank_ctrl.sv
// Load sequencer for weight_bank_loader: IDLE/LOAD/FULL FSM, saturating
// load_count, w_ready/loaded decode and bank_valid.
// Ports: clk, rst (sync, active high); commit (only with WEIGHT_BANK_DBUF_EN)
// pulses when the shadow set is to be copied to the active bank; accept
// marks a beat whose lanes must be written this cycle.
// Macro WEIGHT_BANK_DBUF_EN: double-buffered (bank_valid set on commit);
// otherwise single bank (bank_valid cleared on start, set on reaching FULL).
module weight_bank_ctrl
   import weight_pkg::*;
#(
   parameter int unsigned N_REG = DEF_N_REG,
   parameter int unsigned LANES = DEF_LANES,
   localparam int unsigned CNT_W = cnt_width(N_REG)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef WEIGHT_BANK_DBUF_EN
   output logic             commit,
`endif
   input  logic             start,
   input  logic             swap,
   input  logic             w_valid,
   output logic             accept,
   output logic             w_ready,
   output logic             loaded,
   output logic             bank_valid,
   output logic [CNT_W-1:0] load_count
);
   localparam logic [CNT_W:0]   LANES_X = (CNT_W+1)'(LANES);
   localparam logic [CNT_W:0]   NREG_X  = (CNT_W+1)'(N_REG);
   localparam logic [CNT_W-1:0] NREG_C  = CNT_W'(N_REG);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W:0]   cnt_sum;
   logic [CNT_W-1:0] cnt_sat;
   logic             bv_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         load_count <= '0;
         bank_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         load_count <= cnt_nx;
         bank_valid <= bv_nx;
      end
   end

   always_comb begin
      cnt_sum  = {1'b0, load_count} + LANES_X;
      cnt_sat  = (cnt_sum >= NREG_X) ? NREG_C : cnt_sum[CNT_W-1:0];
      state_nx = state;
      cnt_nx   = load_count;
      bv_nx    = bank_valid;
      accept   = 1'b0;
`ifdef WEIGHT_BANK_DBUF_EN
      commit   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = LOAD;
               cnt_nx   = '0;
`ifndef WEIGHT_BANK_DBUF_EN
               bv_nx    = 1'b0;
`endif
            end
         end
         LOAD: begin
            // a restart drops any beat handshaken in the same cycle
            if (start) begin
               cnt_nx = '0;
`ifndef WEIGHT_BANK_DBUF_EN
               bv_nx  = 1'b0;
`endif
            end else if (w_valid) begin
               accept = 1'b1;
               cnt_nx = cnt_sat;
               if (cnt_sat == NREG_C) begin
                  state_nx = FULL;
`ifndef WEIGHT_BANK_DBUF_EN
                  bv_nx    = 1'b1;
`endif
               end
            end
         end
         FULL: begin
            // swap has priority over a simultaneous start
            if (swap) begin
               state_nx = IDLE;
`ifdef WEIGHT_BANK_DBUF_EN
               commit   = 1'b1;
               bv_nx    = 1'b1;
`endif
            end else if (start) begin
               state_nx = LOAD;
               cnt_nx   = '0;
`ifndef WEIGHT_BANK_DBUF_EN
               bv_nx    = 1'b0;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign w_ready = (state == LOAD);
   assign loaded  = (state == FULL);

endmodule

// File: rtl/weight_bank_loader.sv
// Parametrised weight register bank. Weights arrive LANES per beat over a
// valid/ready stream and fill registers from index N_REG-1 downwards; the
// active bank is presented flattened on all_weight.
// Ports: clk, rst (sync, active high), bus (weight_bank_loader_if.slave).
// Macro WEIGHT_BANK_DBUF_EN: loads go to a shadow bank copied to the active
// bank on swap; otherwise loads write the active bank directly.
module weight_bank_loader
   import weight_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned N_REG = DEF_N_REG,
   parameter int unsigned LANES = DEF_LANES
) (
   input logic                 clk,
   input logic                 rst,
   weight_bank_loader_if.slave bus
);
   logic             accept;
   logic [WIDTH-1:0] active  [N_REG];
   logic             wr_en   [N_REG];
   logic [WIDTH-1:0] wr_data [N_REG];
   logic [WIDTH*N_REG-1:0] flat;
   int unsigned      cnt;
`ifdef WEIGHT_BANK_DBUF_EN
   logic             commit;
   logic [WIDTH-1:0] shadow  [N_REG];
`endif

   weight_bank_ctrl #(
      .N_REG (N_REG),
      .LANES (LANES)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
`ifdef WEIGHT_BANK_DBUF_EN
      .commit     (commit),
`endif
      .start      (bus.start),
      .swap       (bus.swap),
      .w_valid    (bus.w_valid),
      .accept     (accept),
      .w_ready    (bus.w_ready),
      .loaded     (bus.loaded),
      .bank_valid (bus.bank_valid),
      .load_count (bus.load_count)
   );

   // Register r holds load position N_REG-1-r; it is written by lane
   // (pos - load_count) when that lane falls inside the current beat.
   // The modulo only keeps the lane select in range when not enabled.
   always_comb begin
      cnt = 32'(bus.load_count);
      for (int unsigned r = 0; r < N_REG; r++) begin
         wr_en[r]   = accept && ((N_REG - 1 - r) >= cnt) &&
                      ((N_REG - 1 - r) < (cnt + LANES));
         wr_data[r] = bus.w_in[((N_REG - 1 - r - cnt) % LANES) * WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < N_REG; r++) begin
            active[r] <= '0;
`ifdef WEIGHT_BANK_DBUF_EN
            shadow[r] <= '0;
`endif
         end
      end else begin
         for (int unsigned r = 0; r < N_REG; r++) begin
`ifdef WEIGHT_BANK_DBUF_EN
            if (wr_en[r]) shadow[r] <= wr_data[r];
            if (commit)   active[r] <= shadow[r];
`else
            if (wr_en[r]) active[r] <= wr_data[r];
`endif
         end
      end
   end

   always_comb begin
      flat = '0;
      for (int unsigned r = 0; r < N_REG; r++) begin
         flat[r*WIDTH +: WIDTH] = active[r];
      end
   end

   assign bus.all_weight = flat;

endmodule
